// File: rtl/cmos_crop_pack.sv
`timescale 1ns/1ps
// cmos_crop_pack
// Takes the RGB565 pixel stream from the OV5640 capture stage (camera pixel-clock
// domain), keeps a rectangular window of each frame, and packs 8 kept pixels into
// each 128-bit word for the frame-buffer write FIFO.
//
// Ports
//   clk        camera pixel clock, one pixel per de-high cycle
//   rst        synchronous reset, active-high
//   vs_in      frame sync, rising edge starts a frame
//   de_in      pixel valid
//   rgb565_in  pixel {r[4:0],g[5:0],b[4:0]}
//   out_ready  downstream FIFO can accept a word
//   clr_ovf    clears the sticky overflow flag
//   out_valid  out_data holds a valid word
//   out_data   8 pixels, first pixel in bits [15:0]
//   out_sof    first word of the frame
//   out_eol    last word of a kept line
//   frame_done 1-cycle pulse when the last word of the frame is loaded
//   overflow   sticky, a completed word was dropped
module cmos_crop_pack #(
    parameter int X_START = 0,
    parameter int Y_START = 0,
    parameter int OUT_W   = 1280,
    parameter int OUT_H   = 720
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vs_in,
    input  logic         de_in,
    input  logic [15:0]  rgb565_in,
    input  logic         out_ready,
    input  logic         clr_ovf,
    output logic         out_valid,
    output logic [127:0] out_data,
    output logic         out_sof,
    output logic         out_eol,
    output logic         frame_done,
    output logic         overflow
);

    typedef enum logic [1:0] {
        WAIT_VS,
        ACTIVE,
        DONE
    } state_t;

    localparam logic [15:0] X_LO   = 16'(X_START);
    localparam logic [15:0] W16    = 16'(OUT_W);
    localparam logic [15:0] X_LAST = 16'(X_START + OUT_W - 1);
    localparam logic [15:0] Y_LO   = 16'(Y_START);
    localparam logic [15:0] H16    = 16'(OUT_H);
    localparam logic [15:0] Y_LAST = 16'(Y_START + OUT_H - 1);

    logic         vs_q, vsPrev_q, de_q, dePrev_q;
    logic [15:0]  pix_q;
    logic [15:0]  xCnt_q, xCnt_d, yCnt_q, yCnt_d;
    logic [2:0]   packIdx_q, packIdx_d;
    logic [127:0] pack_q, pack_d;
    logic         sofDone_q, sofDone_d;
    state_t       state_q, state_d;
    logic         outValid_q, outValid_d;
    logic [127:0] outData_q, outData_d;
    logic         outSof_q, outSof_d;
    logic         outEol_q, outEol_d;
    logic         frameDone_q, frameDone_d;
    logic         ovf_q, ovf_d;

    logic         vsRise, deFall, keep, wordDone, lastCol, lastLine, canLoad;
    logic [15:0]  xOff, yOff;
    logic [127:0] wordData;

    // Input retiming: the camera signals are registered once, and the previous
    // registered value is kept so that edges are detected on the registered copies.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q     <= 1'b0;
            vsPrev_q <= 1'b0;
            de_q     <= 1'b0;
            dePrev_q <= 1'b0;
            pix_q    <= '0;
        end else begin
            vs_q     <= vs_in;
            vsPrev_q <= vs_q;
            de_q     <= de_in;
            dePrev_q <= de_q;
            pix_q    <= rgb565_in;
        end
    end

    // Window test uses offset arithmetic so a window starting at 0 needs no
    // separate lower-bound compare; negative offsets wrap to large values.
    always_comb begin
        vsRise   = vs_q & ~vsPrev_q;
        deFall   = dePrev_q & ~de_q;
        xOff     = xCnt_q - X_LO;
        yOff     = yCnt_q - Y_LO;
        keep     = (state_q == ACTIVE) && !vsRise && de_q && (xOff < W16) && (yOff < H16);
        wordDone = keep && (packIdx_q == 3'd7);
        lastCol  = (xCnt_q == X_LAST);
        lastLine = (yCnt_q == Y_LAST);
        wordData = {pix_q, pack_q[127:16]};
        canLoad  = !outValid_q || out_ready;
    end

    // Next-state logic. A frame start clears all packing progress but leaves a word
    // already on the output alone; a de fall ends the line and throws away any
    // partially packed group, which is what makes short lines harmless.
    always_comb begin
        xCnt_d      = xCnt_q;
        yCnt_d      = yCnt_q;
        packIdx_d   = packIdx_q;
        pack_d      = pack_q;
        sofDone_d   = sofDone_q;
        state_d     = state_q;
        outValid_d  = outValid_q;
        outData_d   = outData_q;
        outSof_d    = outSof_q;
        outEol_d    = outEol_q;
        frameDone_d = 1'b0;
        ovf_d       = ovf_q;

        if (vsRise) begin
            xCnt_d = '0;
        end else if (deFall) begin
            xCnt_d = '0;
        end else if (de_q) begin
            xCnt_d = xCnt_q + 16'd1;
        end

        if (vsRise) begin
            yCnt_d = '0;
        end else if (deFall) begin
            yCnt_d = yCnt_q + 16'd1;
        end

        if (vsRise || deFall) begin
            packIdx_d = '0;
        end else if (keep) begin
            packIdx_d = packIdx_q + 3'd1;
            pack_d    = wordData;
        end

        case (state_q)
            WAIT_VS: if (vsRise) state_d = ACTIVE;
            ACTIVE:  if (wordDone && lastCol && lastLine) state_d = DONE;
            DONE:    if (vsRise) state_d = ACTIVE;
            default: state_d = WAIT_VS;
        endcase

        if (wordDone && canLoad) begin
            outValid_d = 1'b1;
            outData_d  = wordData;
            outSof_d   = !sofDone_q;
            outEol_d   = lastCol;
        end else if (out_ready) begin
            outValid_d = 1'b0;
            outSof_d   = 1'b0;
            outEol_d   = 1'b0;
        end

        if (vsRise) begin
            sofDone_d = 1'b0;
        end else if (wordDone && canLoad) begin
            sofDone_d = 1'b1;
        end

        frameDone_d = wordDone && lastCol && lastLine;

        if (wordDone && !canLoad) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            xCnt_q      <= '0;
            yCnt_q      <= '0;
            packIdx_q   <= '0;
            pack_q      <= '0;
            sofDone_q   <= 1'b0;
            state_q     <= WAIT_VS;
            outValid_q  <= 1'b0;
            outData_q   <= '0;
            outSof_q    <= 1'b0;
            outEol_q    <= 1'b0;
            frameDone_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            xCnt_q      <= xCnt_d;
            yCnt_q      <= yCnt_d;
            packIdx_q   <= packIdx_d;
            pack_q      <= pack_d;
            sofDone_q   <= sofDone_d;
            state_q     <= state_d;
            outValid_q  <= outValid_d;
            outData_q   <= outData_d;
            outSof_q    <= outSof_d;
            outEol_q    <= outEol_d;
            frameDone_q <= frameDone_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid  = outValid_q;
    assign out_data   = outData_q;
    assign out_sof    = outSof_q;
    assign out_eol    = outEol_q;
    assign frame_done = frameDone_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_cmos_crop_pack.sv
`timescale 1ns/1ps
// tb_cmos_crop_pack
// Drives 32x4 camera frames into cmos_crop_pack (window x 8..23, lines 1..2) and
// compares every transferred word against words built directly from the frame
// pixels that were sent.
module tb_cmos_crop_pack;

    localparam int XS = 8;
    localparam int YS = 1;
    localparam int W  = 16;
    localparam int H  = 2;
    localparam int FW = 32;
    localparam int FH = 4;
    localparam logic [127:0] W0 = 128'h010F010E010D010C010B010A01090108;

    logic         clk = 1'b0;
    logic         rst, vs_in, de_in, out_ready, clr_ovf;
    logic [15:0]  rgb565_in;
    logic         out_valid, out_sof, out_eol, frame_done, overflow;
    logic [127:0] out_data;

    typedef struct {
        logic [127:0] data;
        logic         sof;
        logic         eol;
    } word_t;

    typedef struct {
        string name;
        bit    toggle;
        bit    randPix;
        int    expWords;
        int    expFd;
        logic  expOvf;
    } vec_t;

    word_t        got[$];
    word_t        expQ[$];
    int           fdCount;
    logic [127:0] fdData;
    logic         fdWithValid;
    int           passCount = 0;
    int           checkCount = 0;
    bit           busy;
    logic [15:0]  frameMem [FH][FW];

    cmos_crop_pack #(
        .X_START(XS),
        .Y_START(YS),
        .OUT_W(W),
        .OUT_H(H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vs_in(vs_in),
        .de_in(de_in),
        .rgb565_in(rgb565_in),
        .out_ready(out_ready),
        .clr_ovf(clr_ovf),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_sof(out_sof),
        .out_eol(out_eol),
        .frame_done(frame_done),
        .overflow(overflow)
    );

    // 100 MHz pixel clock.
    always #5 clk = ~clk;

    // Mid-cycle monitor: records every word that transfers on the next rising edge
    // and remembers what was on the output when frame_done pulsed.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            got.push_back('{out_data, out_sof, out_eol});
        end
        if (frame_done) begin
            fdCount++;
            fdData      = out_data;
            fdWithValid = out_valid;
        end
    end

    // Hard time limit so a stuck run still ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached before the end of the test");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] expv);
        checkCount++;
        if (act === expv) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // One camera frame: vs pulse, then FH lines of FW pixels with random blanking.
    // A non-negative abortLine stops the frame mid-line at pixel abortX.
    task automatic applyStimulus(input bit randPix, input int abortLine, input int abortX);
        logic [15:0] pix;
        vs_in = 1'b1;
        repeat (3) tick();
        vs_in = 1'b0;
        repeat (4) tick();
        for (int y = 0; y < FH; y++) begin
            for (int x = 0; x < FW; x++) begin
                if (y == abortLine && x == abortX) begin
                    de_in = 1'b0;
                    tick();
                    return;
                end
                pix = randPix ? 16'($urandom) : 16'(y * 256 + x);
                frameMem[y][x] = pix;
                de_in     = 1'b1;
                rgb565_in = pix;
                tick();
            end
            de_in = 1'b0;
            repeat ($urandom_range(3, 8)) tick();
        end
        repeat (4) tick();
    endtask

    task automatic runFrame(input bit toggle, input bit randPix);
        busy = 1'b1;
        fork
            begin
                applyStimulus(randPix, -1, 0);
                busy = 1'b0;
            end
            begin
                while (busy && toggle) begin
                    tick();
                    out_ready = ~out_ready;
                end
            end
        join
        out_ready = 1'b1;
    endtask

    task automatic waitValid(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checkCount++;
            $display("[TB] FAIL wait_valid: out_valid stayed 0 for %0d cycles, expected 1", budget);
        end
    endtask

    // Reference: the window of the last frame sent, cut into 8-pixel groups.
    function automatic void buildExpected();
        word_t w;
        expQ.delete();
        for (int y = YS; y < YS + H; y++) begin
            for (int g = 0; g < W / 8; g++) begin
                w.data = '0;
                for (int k = 0; k < 8; k++) begin
                    w.data[16*k +: 16] = frameMem[y][XS + 8*g + k];
                end
                w.sof = (y == YS) && (g == 0);
                w.eol = (g == W / 8 - 1);
                expQ.push_back(w);
            end
        end
    endfunction

    task automatic compareWords(input string name);
        int n;
        checkOutput({name, " word count"}, 128'(got.size()), 128'(expQ.size()));
        n = (got.size() < expQ.size()) ? got.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s word%0d data", name, i), got[i].data, expQ[i].data);
            checkOutput($sformatf("%s word%0d sof/eol", name, i),
                        128'({got[i].sof, got[i].eol}), 128'({expQ[i].sof, expQ[i].eol}));
        end
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, " out_valid"}, 128'(out_valid), 128'(0));
        checkOutput({name, " out_data"}, out_data, 128'(0));
        checkOutput({name, " out_sof"}, 128'(out_sof), 128'(0));
        checkOutput({name, " out_eol"}, 128'(out_eol), 128'(0));
        checkOutput({name, " frame_done"}, 128'(frame_done), 128'(0));
        checkOutput({name, " overflow"}, 128'(overflow), 128'(0));
    endtask

    initial begin
        vec_t vecs[4];
        bit   ok;

        vecs[0] = '{"frame_ready1",   1'b0, 1'b0, 4, 1, 1'b0};
        vecs[1] = '{"frame_toggle",   1'b1, 1'b0, 4, 1, 1'b0};
        vecs[2] = '{"rand_ready1",    1'b0, 1'b1, 4, 1, 1'b0};
        vecs[3] = '{"rand_toggle",    1'b1, 1'b1, 4, 1, 1'b0};

        rst = 1'b1; vs_in = 1'b0; de_in = 1'b0; rgb565_in = '0;
        out_ready = 1'b1; clr_ovf = 1'b0; fdCount = 0; fdData = '0; fdWithValid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        tick();

        // Pixels before any frame start must be ignored.
        got.delete();
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < FW; x++) begin
                de_in = 1'b1;
                rgb565_in = 16'(y * 256 + x);
                tick();
            end
            de_in = 1'b0;
            repeat (5) tick();
        end
        checkOutput("pre_vs word count", 128'(got.size()), 128'(0));

        for (int i = 0; i < 4; i++) begin
            got.delete();
            fdCount = 0;
            fdWithValid = 1'b0;
            out_ready = 1'b1;
            runFrame(vecs[i].toggle, vecs[i].randPix);
            buildExpected();
            checkOutput({vecs[i].name, " table count"}, 128'(got.size()), 128'(vecs[i].expWords));
            compareWords(vecs[i].name);
            if (i == 0 && got.size() > 0) begin
                checkOutput("frame_ready1 word0 literal", got[0].data, W0);
            end
            checkOutput({vecs[i].name, " frame_done pulses"}, 128'(fdCount), 128'(vecs[i].expFd));
            checkOutput({vecs[i].name, " frame_done data"}, fdData, expQ[expQ.size() - 1].data);
            checkOutput({vecs[i].name, " frame_done with valid"}, 128'(fdWithValid), 128'(1));
            checkOutput({vecs[i].name, " overflow"}, 128'(overflow), 128'(vecs[i].expOvf));
        end

        // Back-pressure: word0 held for 20 cycles, word1 completes meanwhile and is lost.
        got.delete();
        fdCount = 0;
        out_ready = 1'b0;
        fork
            applyStimulus(1'b0, -1, 0);
            begin
                waitValid(300, ok);
                if (ok) begin
                    for (int c = 0; c < 20; c++) begin
                        checkOutput($sformatf("hold c%0d data", c), out_data, W0);
                        checkOutput($sformatf("hold c%0d valid/sof", c), 128'({out_valid, out_sof}), 128'(2'b11));
                        @(negedge clk);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        buildExpected();
        expQ.delete(1);
        compareWords("backpressure");
        checkOutput("backpressure frame_done pulses", 128'(fdCount), 128'(1));
        checkOutput("backpressure overflow set", 128'(overflow), 128'(1));
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        @(negedge clk);
        checkOutput("overflow cleared", 128'(overflow), 128'(0));
        tick();

        // Frame restarted after 4 kept pixels of line 1: the partial group vanishes.
        got.delete();
        applyStimulus(1'b0, 1, 12);
        applyStimulus(1'b1, -1, 0);
        buildExpected();
        compareWords("restart");

        // Reset while a word is waiting: outputs clear, nothing until the next frame.
        out_ready = 1'b0;
        fork
            applyStimulus(1'b0, -1, 0);
            begin
                waitValid(300, ok);
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                checkAllZero("mid_reset");
                rst = 1'b0;
                out_ready = 1'b1;
                got.delete();
            end
        join
        checkOutput("after_reset word count", 128'(got.size()), 128'(0));
        got.delete();
        runFrame(1'b0, 1'b1);
        buildExpected();
        compareWords("after_reset_frame");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
